// File: rtl/sram_arbiter.sv
// Byte-wide async SRAM controller arbitrating video byte reads against 4-byte host word transfers.
// Define SRAM_ARB_HOST_READ_EN to enable host word reads; otherwise the host port is write-only.
module sram_arbiter #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vid_req,
    input  logic [18:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [18:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_ack,
    output logic [31:0] host_rdata,
    output logic [18:0] sram_addr,
    output logic        sram_we_n,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_i,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, VRD, HSETUP, HWR, HHOLD, HRD} state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

    state_t      state_q, state_d;
    logic [18:0] addr_q, addr_d;
    logic        weN_q, weN_d;
    logic [7:0]  dqO_q, dqO_d;
    logic        dqOe_q, dqOe_d;
    logic        vidAck_q, vidAck_d;
    logic        hostAck_q, hostAck_d;
    logic [7:0]  vidData_q, vidData_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        lastVid_q, lastVid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic       vidElig, hostElig, grantVid, grantHost, hostWrite;
    logic [7:0] wrByte;
    logic       unusedBits;

`ifdef SRAM_ARB_HOST_READ_EN
    assign hostWrite  = host_we;
    assign host_rdata = rdata_q;
`else
    assign hostWrite  = 1'b1;
    assign host_rdata = 32'd0;
`endif

    assign unusedBits = ^{host_addr[1:0], host_we, rdata_q};

    // A requester whose ack is still showing is not eligible; a video slot yields to a waiting host
    assign vidElig   = vid_req & ~vidAck_q;
    assign hostElig  = host_req & ~hostAck_q;
    assign grantVid  = vidElig & ~(lastVid_q & hostElig);
    assign grantHost = hostElig & ~grantVid;
    assign wrByte    = (idx_q == 2'd0) ? host_wdata[7:0] : wdata_q[{idx_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grantVid)       state_d = VRD;
                else if (grantHost) state_d = hostWrite ? HSETUP : HRD;
            end
            VRD:    if (cnt_q == 4'd0) state_d = IDLE;
            HSETUP: state_d = HWR;
            HWR:    if (cnt_q == 4'd0) state_d = HHOLD;
            HHOLD:  state_d = IDLE;
            HRD:    if (cnt_q == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        weN_d     = weN_q;
        dqO_d     = dqO_q;
        dqOe_d    = dqOe_q;
        vidAck_d  = 1'b0;
        hostAck_d = 1'b0;
        vidData_d = vidData_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        lastVid_d = lastVid_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (grantVid) begin
                    addr_d    = vid_addr;
                    cnt_d     = RD_LOAD;
                    lastVid_d = 1'b1;
                end else if (grantHost) begin
                    addr_d    = {host_addr[18:2], idx_q};
                    lastVid_d = 1'b0;
                    if (hostWrite) begin
                        cnt_d  = WR_LOAD;
                        dqOe_d = 1'b1;
                        dqO_d  = wrByte;
                        if (idx_q == 2'd0) wdata_d = host_wdata;
                    end else begin
                        cnt_d = RD_LOAD;
                    end
                end
            end
            VRD: begin
                if (cnt_q == 4'd0) begin
                    vidData_d = sram_dq_i;
                    vidAck_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HSETUP: weN_d = 1'b0;
            HWR: begin
                if (cnt_q == 4'd0) weN_d = 1'b1;
                else               cnt_d = cnt_q - 4'd1;
            end
            HHOLD: begin
                dqOe_d    = 1'b0;
                idx_d     = idx_q + 2'd1;
                hostAck_d = (idx_q == 2'd3);
            end
`ifdef SRAM_ARB_HOST_READ_EN
            HRD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d[{idx_q, 3'b000} +: 8] = sram_dq_i;
                    idx_d     = idx_q + 2'd1;
                    hostAck_d = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= 19'd0;
            weN_q     <= 1'b1;
            dqO_q     <= 8'd0;
            dqOe_q    <= 1'b0;
            vidAck_q  <= 1'b0;
            hostAck_q <= 1'b0;
            vidData_q <= 8'd0;
            cnt_q     <= 4'd0;
            idx_q     <= 2'd0;
            lastVid_q <= 1'b0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            addr_q    <= addr_d;
            weN_q     <= weN_d;
            dqO_q     <= dqO_d;
            dqOe_q    <= dqOe_d;
            vidAck_q  <= vidAck_d;
            hostAck_q <= hostAck_d;
            vidData_q <= vidData_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            lastVid_q <= lastVid_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_we_n  = weN_q;
    assign sram_dq_o  = dqO_q;
    assign sram_dq_oe = dqOe_q;
    assign vid_ack    = vidAck_q;
    assign vid_data   = vidData_q;
    assign host_ack   = hostAck_q;
    assign busy       = (state_q != IDLE);

endmodule
